stream_mux_rr: RTL
==================

// Module: stream_mux_rr
// PURPOSE
//   Parametrised N:1 registered stream multiplexer; successor to the combinational 2:1 mux.
//   Selects one of N_CH valid/ready input channels, either fixed (sel port) or round-robin,
//   and drives a one-entry registered output stage tagged with the source channel index.
//   Sits between multiple producers and one shared consumer (bus, FIFO, UART tx path).
// PARAMETERS
//   N_CH   4   number of input channels (>=2)
//   WIDTH  8   data width per channel
//   CH_W   $clog2(N_CH)  channel index width (derived, do not override)
// PORTS
//   clk        in   1             rising-edge clock, sole clock domain
//   rst        in   1             synchronous reset, active-high
//   rr_en      in   1             1 = round-robin arbitration, 0 = fixed select via sel
//   sel        in   CH_W          fixed-mode channel select
//   in_data    in   N_CH*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid   in   N_CH          per-channel valid
//   in_ready   out  N_CH          per-channel ready (one-hot or zero)
//   out_data   out  WIDTH         registered output data
//   out_ch     out  CH_W          index of channel that produced out_data
//   out_valid  out  1             output valid
//   out_ready  in   1             consumer ready
// BEHAVIOUR
//   - One clock, synchronous active-high reset on rst; all state updates on posedge clk.
//   - Reset: out_valid=0, out_data=0, out_ch=0, rr pointer last_grant=N_CH-1 (ch0 wins first).
//   - load = ~out_valid | out_ready (output slot free or draining this cycle).
//   - grant (combinational, one-hot or zero):
//       fixed (rr_en=0): grant[sel] = in_valid[sel]; sel >= N_CH -> no grant.
//       rr   (rr_en=1): first valid channel searching last_grant+1 .. last_grant (wrapping mod N_CH).
//   - in_ready = grant & {N_CH{load}}; a transfer on ch i is in_valid[i] & in_ready[i].
//   - On transfer: out_data<=in_data[i], out_ch<=i, out_valid<=1; last_grant<=i (both modes).
//   - load & no grant: out_valid<=0; out_data/out_ch hold last values.
//   - ~load (out_valid & ~out_ready): out_data, out_ch, out_valid held stable; all in_ready=0.
//   - Latency: input accepted in cycle t appears on out_* in cycle t+1; full throughput
//     (one word/cycle) when out_ready held high.
//   - Fairness: in rr mode with all channels valid and out_ready=1, grants cycle 0,1,..,N_CH-1,0.
//   - rr_en or sel change: affects arbitration from the same cycle; held output not disturbed.
//   - Reset mid-transfer: pending output word dropped; out_valid=0 next cycle; no in_ready during rst.
//   - Channel id width arithmetic: pointer increment wraps at N_CH (not 2^CH_W) for non-power-of-2 N_CH.
// STRUCTURE
//   - Package stream_mux_pkg: MODE_FIXED=1'b0 / MODE_RR=1'b1 constants, clog2 helper function.
//   - Sub-module rr_arbiter (params N_CH): inputs req, last_grant, outputs one-hot grant and
//     encoded index; purely combinational, pointer register stays in stream_mux_rr.
//   - Top: fixed-select decode, mode mux on grant, data select, output register + pointer register.
// TESTING
//   1 Reset: assert rst 3 cycles with all in_valid=1 -> out_valid=0, in_ready=0, out_data=0 throughout.
//   2 Fixed mode, sel=2, in_data ch2=0xA5, in_valid=4'b1111, out_ready=1 -> in_ready=4'b0100,
//     next cycle out_data=0xA5, out_ch=2, out_valid=1; sel=5 (N_CH=6 build) invalid-range check for sel=7 -> no grant.
//   3 RR, all valid, out_ready=1, 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3.
//   4 RR, only ch1 and ch3 valid -> out_ch alternates 1,3,1,3; ch0/ch2 in_ready never 1.
//   5 Backpressure: out_ready=0 for 4 cycles while out_valid=1 -> out_data/out_ch stable, in_ready=0;
//     out_ready=1 -> next word loads same cycle, no word lost or duplicated (scoreboard count).
//   6 Reset mid-stream: rst in cycle with out_valid=1 -> out_valid=0 next cycle, first post-reset grant ch0.

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the N:1 registered stream multiplexer.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2, usable in constant expressions; callers guarantee v >= 2.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Producer/consumer stream bundle around stream_mux_rr; slave is the mux side.
interface stream_mux_rr_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8
) ();
    localparam int unsigned CH_W = stream_mux_pkg::clog2(N_CH);

    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [CH_W-1:0]       out_ch;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant, wrapping at N_CH.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int unsigned N_CH = 4,
    localparam int unsigned CH_W = clog2(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [CH_W-1:0] last_grant_i,
    output logic [N_CH-1:0] grant_o,
    output logic [CH_W-1:0] idx_o
);

    logic        found;
    int unsigned c;

    // Modulo N_CH rather than 2^CH_W so non-power-of-2 channel counts wrap correctly.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        c       = 0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            c = (32'(last_grant_i) + k) % N_CH;
            if (!found && req_i[CH_W'(c)]) begin
                found               = 1'b1;
                grant_o[CH_W'(c)]   = 1'b1;
                idx_o               = CH_W'(c);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready multiplexer, fixed or round-robin select, one-entry registered output.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int unsigned N_CH  = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CH_W  = clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rr_en,
    input  logic [CH_W-1:0] sel,
    stream_mux_rr_if.slave  bus
);

    logic                  load;
    logic [N_CH-1:0]       fix_grant;
    logic [N_CH-1:0]       arb_grant;
    logic [N_CH-1:0]       grant;
    logic [CH_W-1:0]       arb_idx;
    logic [CH_W-1:0]       grant_idx;
    logic [WIDTH-1:0]      sel_data;

    logic [WIDTH-1:0]      out_data_q, out_data_d;
    logic [CH_W-1:0]       out_ch_q, out_ch_d;
    logic                  out_valid_q, out_valid_d;
    logic [CH_W-1:0]       last_grant_q, last_grant_d;

    always_comb begin
        fix_grant = '0;
        if (32'(sel) < N_CH) begin
            fix_grant[sel] = bus.in_valid[sel];
        end
    end

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req_i        (bus.in_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .idx_o        (arb_idx)
    );

    always_comb begin
        if (rr_en == MODE_RR) begin
            grant     = arb_grant;
            grant_idx = arb_idx;
        end else begin
            grant     = fix_grant;
            grant_idx = sel;
        end
    end

    // Grant is one-hot or zero, so an OR-reduction mux is sufficient.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load = ~out_valid_q | bus.out_ready;

    always_comb begin
        if (rst) begin
            bus.in_ready = '0;
        end else begin
            bus.in_ready = grant & {N_CH{load}};
        end
    end

    always_comb begin
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (load) begin
            if (|grant) begin
                out_data_d   = sel_data;
                out_ch_d     = grant_idx;
                out_valid_d  = 1'b1;
                last_grant_d = grant_idx;
            end else begin
                out_valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= CH_W'(N_CH - 1);
        end else begin
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

endmodule
